// File: rtl/disp_ctrl_pkg.sv
// Shared constants for the display mode and time-setting controller.
package disp_ctrl_pkg;

  localparam logic [2:0] SHOW_TIME = 3'd0;
  localparam logic [2:0] SHOW_ALM  = 3'd1;
  localparam logic [2:0] SET_TH    = 3'd2;
  localparam logic [2:0] SET_TM    = 3'd3;
  localparam logic [2:0] SET_AH    = 3'd4;
  localparam logic [2:0] SET_AM    = 3'd5;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  localparam int unsigned DEF_BLINK_DIV = 12_500_000;
  localparam int unsigned DEF_TIMEOUT   = 500_000_000;

  function automatic logic is_set_state(input logic [2:0] s);
    return (s >= SET_TH) && (s <= SET_AM);
  endfunction

endpackage

// File: rtl/disp_mode_ctrl_bcd_inc.sv
// Packed-BCD +1 with decimal carry; anything past the limit wraps to 00.
module bcd_inc
  import disp_ctrl_pkg::*;
(
  input  logic [7:0] value_i,
  input  logic [7:0] limit_i,
  output logic [7:0] value_o
);

  logic [7:0] stepped;

  // Out-of-range captures land above the limit and therefore collapse to 00.
  always_comb begin
    if (value_i[3:0] >= 4'd9) begin
      stepped = {value_i[7:4] + 4'd1, 4'd0};
    end else begin
      stepped = {value_i[7:4], value_i[3:0] + 4'd1};
    end
    value_o = (stepped > limit_i) ? 8'h00 : stepped;
  end

endmodule

// File: rtl/disp_mode_ctrl.sv
// Chooses what the 4-digit display shows and runs the button-driven
// time/alarm set state machine with field blinking and idle abort.
module disp_mode_ctrl
  import disp_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_DIV = DEF_BLINK_DIV,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic [7:0] Hour_in,
  input  logic [7:0] Minute_in,
  output logic [7:0] Hour,
  output logic [7:0] Minute,
  output logic [3:0] blank,
  output logic       set_load,
  output logic [7:0] set_Hour,
  output logic [7:0] set_Minute,
  output logic [7:0] alarm_Hour,
  output logic [7:0] alarm_Minute,
  output logic [2:0] state
);

  logic [2:0]  state_q, state_d;
  logic [7:0]  edit_h_q, edit_h_d, edit_m_q, edit_m_d;
  logic [7:0]  alarm_h_q, alarm_h_d, alarm_m_q, alarm_m_d;
  logic [7:0]  hour_q, hour_d, minute_q, minute_d;
  logic [3:0]  blank_q, blank_d;
  logic        set_load_q, set_load_d;
  logic [7:0]  set_hour_q, set_hour_d, set_min_q, set_min_d;
  logic [31:0] blink_cnt_q, blink_cnt_d, idle_q, idle_d;
  logic        blink_q, blink_d;
  logic [7:0]  inc_h, inc_m;
  logic [2:0]  abort_state;
  logic        do_mode, do_sel, do_inc, any_btn, timeout_hit;

  bcd_inc u_hour_inc (.value_i(edit_h_q), .limit_i(HOUR_MAX), .value_o(inc_h));
  bcd_inc u_min_inc  (.value_i(edit_m_q), .limit_i(MIN_MAX),  .value_o(inc_m));

  assign do_mode     = btn_mode;
  assign do_sel      = btn_sel & ~btn_mode;
  assign do_inc      = btn_inc & ~btn_sel & ~btn_mode;
  assign any_btn     = btn_mode | btn_sel | btn_inc;
  assign timeout_hit = is_set_state(state_q) && !any_btn && (idle_q == TIMEOUT - 1);
  assign abort_state = ((state_q == SET_AH) || (state_q == SET_AM)) ? SHOW_ALM : SHOW_TIME;

  always_comb begin
    state_d    = state_q;
    edit_h_d   = edit_h_q;
    edit_m_d   = edit_m_q;
    alarm_h_d  = alarm_h_q;
    alarm_m_d  = alarm_m_q;
    set_load_d = 1'b0;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    case (state_q)
      SHOW_TIME: begin
        if (do_mode) begin
          state_d = SHOW_ALM;
        end else if (do_sel) begin
          state_d  = SET_TH;
          edit_h_d = Hour_in;
          edit_m_d = Minute_in;
        end
      end
      SHOW_ALM: begin
        if (do_mode) begin
          state_d = SHOW_TIME;
        end else if (do_sel) begin
          state_d  = SET_AH;
          edit_h_d = alarm_h_q;
          edit_m_d = alarm_m_q;
        end
      end
      SET_TH, SET_AH: begin
        if (do_mode || timeout_hit) begin
          state_d = abort_state;
        end else if (do_sel) begin
          state_d = (state_q == SET_TH) ? SET_TM : SET_AM;
        end else if (do_inc) begin
          edit_h_d = inc_h;
        end
      end
      SET_TM, SET_AM: begin
        if (do_mode || timeout_hit) begin
          state_d = abort_state;
        end else if (do_sel) begin
          if (state_q == SET_TM) begin
            state_d    = SHOW_TIME;
            set_load_d = 1'b1;
            set_hour_d = edit_h_q;
            set_min_d  = edit_m_q;
          end else begin
            state_d   = SHOW_ALM;
            alarm_h_d = edit_h_q;
            alarm_m_d = edit_m_q;
          end
        end else if (do_inc) begin
          edit_m_d = inc_m;
        end
      end
      default: state_d = SHOW_TIME;
    endcase
  end

  // Blink restarts on every state change or increment so the edited field is visible at once.
  always_comb begin
    if ((state_d != state_q) || btn_inc) begin
      blink_cnt_d = 32'd0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_DIV - 1) begin
      blink_cnt_d = 32'd0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 32'd1;
      blink_d     = blink_q;
    end
    if (!is_set_state(state_d) || (state_d != state_q) || any_btn) begin
      idle_d = 32'd0;
    end else begin
      idle_d = idle_q + 32'd1;
    end
  end

  always_comb begin
    hour_d   = Hour_in;
    minute_d = Minute_in;
    blank_d  = 4'b0000;
    case (state_q)
      SHOW_ALM: begin
        hour_d   = alarm_h_q;
        minute_d = alarm_m_q;
      end
      SET_TH, SET_AH: begin
        hour_d   = edit_h_q;
        minute_d = edit_m_q;
        blank_d  = blink_q ? 4'b1100 : 4'b0000;
      end
      SET_TM, SET_AM: begin
        hour_d   = edit_h_q;
        minute_d = edit_m_q;
        blank_d  = blink_q ? 4'b0011 : 4'b0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state_q     <= SHOW_TIME;
      edit_h_q    <= 8'h00;
      edit_m_q    <= 8'h00;
      alarm_h_q   <= 8'h00;
      alarm_m_q   <= 8'h00;
      hour_q      <= 8'h00;
      minute_q    <= 8'h00;
      blank_q     <= 4'b0000;
      set_load_q  <= 1'b0;
      set_hour_q  <= 8'h00;
      set_min_q   <= 8'h00;
      blink_cnt_q <= 32'd0;
      blink_q     <= 1'b0;
      idle_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      edit_h_q    <= edit_h_d;
      edit_m_q    <= edit_m_d;
      alarm_h_q   <= alarm_h_d;
      alarm_m_q   <= alarm_m_d;
      hour_q      <= hour_d;
      minute_q    <= minute_d;
      blank_q     <= blank_d;
      set_load_q  <= set_load_d;
      set_hour_q  <= set_hour_d;
      set_min_q   <= set_min_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      idle_q      <= idle_d;
    end
  end

  assign Hour         = hour_q;
  assign Minute       = minute_q;
  assign blank        = blank_q;
  assign set_load     = set_load_q;
  assign set_Hour     = set_hour_q;
  assign set_Minute   = set_min_q;
  assign alarm_Hour   = alarm_h_q;
  assign alarm_Minute = alarm_m_q;
  assign state        = state_q;

endmodule
